pipelined_instr_proc: RTL and testbench



---
 rtl/pipelined_instr_proc.sv | 139 +++++++++++++
 tb/tb_pipelined_instr_proc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_instr_proc.sv
// Two-stage instruction processor: instruction register (S1) feeding execute/writeback (S2)
// with valid/ready handshakes, zero/overflow flags, a retired counter and a debug read port.
module pipelined_instr_proc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       in_instr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_ovf,
    output logic [2:0]        out_dest,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_ANDI = 3'b011;
    localparam logic [2:0] OP_ORI  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    logic [15:0]       r_ir;
    logic              r_ir_valid;
    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_zero;
    logic              r_out_ovf;
    logic [2:0]        r_out_dest;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_retired;

    logic              w_commit;
    logic              w_accept;
    logic [2:0]        w_op;
    logic [5:0]        w_imm;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_res;
    logic [2:0]        w_dest;
    logic              w_ovf;

    assign w_commit = r_ir_valid & (~r_out_valid | out_ready);
    assign in_ready = ~r_ir_valid | w_commit;
    assign w_accept = in_valid & in_ready;

    assign w_op  = r_ir[15:13];
    assign w_imm = r_ir[5:0];
    assign w_a   = r_regs[r_ir[12:10]];

    always_comb begin
        w_b    = r_regs[r_ir[9:7]];
        w_dest = r_ir[6:4];
        w_res  = '0;
        w_ovf  = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_res = w_a + w_b;
                w_ovf = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
            end
            OP_SUB: begin
                w_res = w_a - w_b;
                w_ovf = (w_a[DATA_W-1] != w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
            end
            OP_ADDI: begin
                w_dest = r_ir[9:7];
                w_b    = {{(DATA_W-6){w_imm[5]}}, w_imm};
                w_res  = w_a + w_b;
                w_ovf  = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != w_a[DATA_W-1]);
            end
            OP_ANDI: begin
                w_dest = r_ir[9:7];
                w_b    = {{(DATA_W-6){1'b0}}, w_imm};
                w_res  = w_a & w_b;
            end
            OP_ORI: begin
                w_dest = r_ir[9:7];
                w_b    = {{(DATA_W-6){1'b0}}, w_imm};
                w_res  = w_a | w_b;
            end
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            default: w_res = '0;
        endcase
    end

    // Writeback and the next accept share an edge, so a dependent instruction reads the updated regfile in S2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir        <= '0;
            r_ir_valid  <= 1'b0;
            r_regs      <= '{default: '0};
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_dest  <= '0;
            r_out_valid <= 1'b0;
            r_retired   <= '0;
        end else begin
            if (w_accept) begin
                r_ir       <= in_instr;
                r_ir_valid <= 1'b1;
            end else if (w_commit) begin
                r_ir_valid <= 1'b0;
            end

            if (w_commit) begin
                r_regs[w_dest] <= w_res;
                r_out_data     <= w_res;
                r_out_zero     <= (w_res == '0);
                r_out_ovf      <= w_ovf;
                r_out_dest     <= w_dest;
                r_out_valid    <= 1'b1;
                r_retired      <= r_retired + CNT_W'(1);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign out_ovf   = r_out_ovf;
    assign out_dest  = r_out_dest;
    assign out_valid = r_out_valid;
    assign retired   = r_retired;
    assign dbg_data  = r_regs[dbg_addr];

endmodule

// File: tb/tb_pipelined_instr_proc.sv
// Directed self-checking bench for pipelined_instr_proc (DATA_W=8, CNT_W=16).
module tb_pipelined_instr_proc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_ovf;
    logic [2:0]  out_dest;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
    logic [15:0] retired;

    int total  = 0;
    int passed = 0;

    pipelined_instr_proc #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_zero(out_zero), .out_ovf(out_ovf), .out_dest(out_dest),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
        dbg_addr = r;
        #1;
        chk(tag, 32'(dbg_data), exp);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic z, input logic v,
                           input logic [2:0] dst);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_zero"},  32'(out_zero),  32'(z));
        chk({tag, "_ovf"},   32'(out_ovf),   32'(v));
        chk({tag, "_dest"},  32'(out_dest),  32'(dst));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset then idle
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_reg("rst_dbg", 3'(i), 32'd0);
        end

        // Single instruction: addi R0,R0,6
        out_ready = 1'b1;
        in_instr  = 16'h4006;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_lat_valid", 32'(out_valid), 32'd0);
        chk("single_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("single", 8'd6, 1'b0, 1'b0, 3'd0);
        chk_reg("single_r0", 3'd0, 32'd6);
        chk("single_retired", 32'(retired), 32'd1);
        tick();
        chk("single_drain", 32'(out_valid), 32'd0);

        // Back-to-back dependency from fresh reset, then sub R2=R0-R0
        do_reset();
        in_instr = 16'h4006;
        in_valid = 1'b1;
        tick();
        tick();
        chk_out("b2b_first", 8'd6, 1'b0, 1'b0, 3'd0);
        in_instr = 16'h2020;
        tick();
        chk_out("b2b_second", 8'd12, 1'b0, 1'b0, 3'd0);
        chk_reg("b2b_r0", 3'd0, 32'd12);
        in_instr = 16'h8DBF;
        tick();
        chk_out("b2b_sub", 8'd0, 1'b1, 1'b0, 3'd2);

        // Overflow sequence (R2=0 and R1=0 going in)
        in_instr = 16'h0DC0;
        tick();
        chk_out("ovf_ori", 8'd63, 1'b0, 1'b0, 3'd3);
        in_instr = 16'h1250;
        tick();
        chk_out("ovf_add126", 8'd126, 1'b0, 1'b0, 3'd4);
        in_instr = 16'h44A0;
        tick();
        chk_out("ovf_addfc", 8'hFC, 1'b0, 1'b1, 3'd5);
        in_valid = 1'b0;
        tick();
        chk_out("ovf_addi", 8'hE0, 1'b0, 1'b0, 3'd1);
        chk("ovf_retired", 32'(retired), 32'd7);
        tick();
        chk("ovf_drain", 32'(out_valid), 32'd0);

        // Backpressure: R0=0+6, then R1=R0-1 held behind the stalled result
        do_reset();
        out_ready = 1'b0;
        in_instr  = 16'h4006;
        in_valid  = 1'b1;
        tick();
        in_instr = 16'h40BF;
        tick();
        in_valid = 1'b0;
        chk_out("bp_first", 8'd6, 1'b0, 1'b0, 3'd0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk_out("bp_hold", 8'd6, 1'b0, 1'b0, 3'd0);
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_retired", 32'(retired), 32'd1);
        chk_reg("bp_hold_r1", 3'd1, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("bp_second", 8'd5, 1'b0, 1'b0, 3'd1);
        chk("bp_retired", 32'(retired), 32'd2);
        chk_reg("bp_r1", 3'd1, 32'd5);
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Reset one cycle after accepting ori R3
        in_instr = 16'h8DBF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk_reg("mid_rst_r3", 3'd3, 32'd0);
        tick();
        chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        chk_reg("mid_rst_r3_later", 3'd3, 32'd0);

        // Reset together with in_valid: instruction must not be accepted
        reset    = 1'b1;
        in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_win_out_valid", 32'(out_valid), 32'd0);
        chk("rst_win_retired", 32'(retired), 32'd0);
        chk_reg("rst_win_r3", 3'd3, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
